// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the digit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of digit steps needed to cover the full operand width.
  function automatic int steps_of(input int width, input int digit);
    return width / digit;
  endfunction

  function automatic bit width_ok(input int width, input int digit);
    return (digit >= 1) && (digit <= width) && ((width % digit) == 0);
  endfunction

endpackage

// File: rtl/serial_sub_digit.sv
// Combinational DIGIT-bit ripple of full-subtractor cells: {bout, d} = a - b - bin.
module sub_digit
  import serial_sub_pkg::*;
#(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             bin,
  output logic [DIGIT-1:0] d,
  output logic             bout
);

  logic [DIGIT:0] c;

  assign c[0] = bin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_cell
    assign d[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & c[i]);
  end

  assign bout = c[DIGIT];

endmodule

// File: rtl/serial_sub.sv
// Multi-cycle subtractor: diff = a - b - bin, DIGIT bits per clock, start/done handshake.
// Optional build macro SERIAL_SUB_SAT_EN: saturate to zero on unsigned underflow.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero
);

  localparam int STEPS = steps_of(WIDTH, DIGIT);
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  if (!width_ok(WIDTH, DIGIT)) begin : g_bad_width
    $error("serial_sub: WIDTH must be a non-zero multiple of DIGIT");
  end

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_sh, b_sh, diff_q;
  logic             brw, zero_q;

  logic [DIGIT-1:0] d_dig;
  logic             brw_dig;
  logic             last;
  logic [WIDTH-1:0] diff_sh, diff_fin;

  sub_digit #(.DIGIT(DIGIT)) u_digit (
    .a    (a_sh[DIGIT-1:0]),
    .b    (b_sh[DIGIT-1:0]),
    .bin  (brw),
    .d    (d_dig),
    .bout (brw_dig)
  );

  assign last    = (state == RUN) && (cnt == CNT_W'(STEPS - 1));
  // New digit enters at the MSB end, so after STEPS shifts the LSB digit sits at bit 0.
  assign diff_sh = (diff_q >> DIGIT) | (WIDTH'(d_dig) << (WIDTH - DIGIT));

`ifdef SERIAL_SUB_SAT_EN
  assign diff_fin = brw_dig ? '0 : diff_sh;
`else
  assign diff_fin = diff_sh;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      a_sh   <= '0;
      b_sh   <= '0;
      brw    <= 1'b0;
      diff_q <= '0;
      zero_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh <= a;
            b_sh <= b;
            brw  <= bin;
            cnt  <= '0;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> DIGIT;
          b_sh   <= b_sh >> DIGIT;
          brw    <= brw_dig;
          cnt    <= cnt + CNT_W'(1);
          diff_q <= last ? diff_fin : diff_sh;
          if (last) zero_q <= (diff_fin == '0);
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign diff = diff_q;
  assign bout = brw;
  assign zero = zero_q;

endmodule
